// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolver: one 3-pixel column per valid, runtime signed kernel, saturated pixel out.
// Latency 2 cycles from the window-completing column, no backpressure; `define CONV_ABS_EN takes |sum| before clamping.
module conv3x3_stream #(
   parameter int DATA_WIDTH   = 8,
   parameter int COEF_WIDTH   = 8,
   parameter int KERNEL_WIDTH = 3,
   parameter int IMAGE_WIDTH  = 10,
   parameter int IMAGE_HEIGHT = 10,
   parameter int SHIFT        = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_kernel_valid,
   input  logic [COEF_WIDTH-1:0] i_kernel_coef,
   input  logic                  i_valid_data_to_conv,
   input  logic [DATA_WIDTH-1:0] i_to_conv0,
   input  logic [DATA_WIDTH-1:0] i_to_conv1,
   input  logic [DATA_WIDTH-1:0] i_to_conv2,
   output logic [DATA_WIDTH-1:0] o_pixel,
   output logic                  o_valid_pixel,
   output logic                  o_kernel_ready,
   output logic                  o_busy,
   output logic                  o_frame_done
);

   localparam int K     = KERNEL_WIDTH;
   localparam int NTAPS = K * K;
   localparam int PW    = DATA_WIDTH + COEF_WIDTH + 1;
   localparam int SUMW  = PW + 4;
   localparam int CW    = $clog2(IMAGE_WIDTH);
   localparam int RW    = $clog2(IMAGE_HEIGHT);
   localparam int IW    = $clog2(NTAPS);

   localparam logic [CW-1:0]          COL_LAST   = CW'(IMAGE_WIDTH - 1);
   localparam logic [CW-1:0]          COL_FULL   = CW'(2);
   localparam logic [RW-1:0]          STRIP_LAST = RW'(IMAGE_HEIGHT - 3);
   localparam logic [IW-1:0]          IDX_LAST   = IW'(NTAPS - 1);
   localparam logic signed [SUMW-1:0] PIX_MAX    = SUMW'((1 << DATA_WIDTH) - 1);

   typedef enum logic [1:0] {KLOAD, READY, RUN, DRAIN} state_t;

   state_t                       state;
   logic [IW-1:0]                idx;
   logic [CW-1:0]                col_cnt;
   logic [RW-1:0]                strip_cnt;
   logic [1:0]                   drain_cnt;
   logic signed [COEF_WIDTH-1:0] coef [NTAPS];
   logic [DATA_WIDTH-1:0]        win  [K][K];
   logic                         win_vld;
   logic signed [PW-1:0]         prod [NTAPS];
   logic                         prod_vld;

   logic col_take;
   logic col_wrap;
   logic frame_last;

   assign col_take   = i_valid_data_to_conv && (state == READY || state == RUN);
   assign col_wrap   = (col_cnt == COL_LAST);
   assign frame_last = col_take && col_wrap && (strip_cnt == STRIP_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= KLOAD;
         idx            <= '0;
         col_cnt        <= '0;
         strip_cnt      <= '0;
         drain_cnt      <= '0;
         win_vld        <= 1'b0;
         o_kernel_ready <= 1'b0;
         o_busy         <= 1'b0;
         o_frame_done   <= 1'b0;
         for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
      end else begin
         o_frame_done <= 1'b0;
         win_vld      <= 1'b0;
         case (state)
            KLOAD: begin
               if (i_kernel_valid) begin
                  coef[idx] <= $signed(i_kernel_coef);
                  if (idx == IDX_LAST) begin
                     idx            <= '0;
                     o_kernel_ready <= 1'b1;
                     state          <= READY;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            READY: begin
               if (i_valid_data_to_conv) begin
                  state  <= RUN;
                  o_busy <= 1'b1;
               end else if (i_kernel_valid) begin
                  state          <= KLOAD;
                  idx            <= '0;
                  o_kernel_ready <= 1'b0;
               end
            end
            RUN: begin
               if (frame_last) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            DRAIN: begin
               // Two pipeline stages still hold the final pixel; finish one cycle after it leaves.
               if (drain_cnt == 2'd2) begin
                  state        <= READY;
                  o_busy       <= 1'b0;
                  o_frame_done <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: state <= KLOAD;
         endcase

         if (col_take) begin
            win_vld <= (col_cnt >= COL_FULL);
            if (col_wrap) begin
               col_cnt   <= '0;
               strip_cnt <= (strip_cnt == STRIP_LAST) ? '0 : strip_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
         end
      end
   end

   // Window indexed [column][row]; column 0 is the oldest (leftmost).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++) win[c][r] <= '0;
      end else if (col_take) begin
         win[0]    <= win[1];
         win[1]    <= win[2];
         win[2][0] <= i_to_conv0;
         win[2][1] <= i_to_conv1;
         win[2][2] <= i_to_conv2;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prod_vld <= 1'b0;
         for (int i = 0; i < NTAPS; i++) prod[i] <= '0;
      end else begin
         prod_vld <= win_vld;
         if (win_vld) begin
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++)
                  prod[r*K+c] <= PW'($signed({1'b0, win[c][r]})) * PW'(coef[r*K+c]);
         end
      end
   end

   logic signed [SUMW-1:0] sum;
   logic signed [SUMW-1:0] shifted;
   logic signed [SUMW-1:0] mag;
   logic [DATA_WIDTH-1:0]  pix_sat;

   always_comb begin
      sum = '0;
      for (int i = 0; i < NTAPS; i++) sum = sum + SUMW'(prod[i]);
      shifted = sum >>> SHIFT;
`ifdef CONV_ABS_EN
      mag = shifted[SUMW-1] ? -shifted : shifted;
`else
      mag = shifted;
`endif
      if (mag[SUMW-1])
         pix_sat = '0;
      else if (mag > PIX_MAX)
         pix_sat = '1;
      else
         pix_sat = mag[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_pixel       <= '0;
         o_valid_pixel <= 1'b0;
      end else begin
         o_valid_pixel <= prod_vld;
         if (prod_vld) o_pixel <= pix_sat;
      end
   end

endmodule
